// File: rtl/data_checker_pkg.sv
// Shared types and constants for the incrementing-sequence data checker.
package data_checker_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] SEQ_WRAP = 32'hffffffff;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Successor of a word in the modulo-2^32 incrementing sequence.
  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] d);
    return (d == SEQ_WRAP) ? '0 : d + 1'b1;
  endfunction

endpackage

// File: rtl/data_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/data_checker.sv
// Incrementing-sequence checker: IDLE -> ACQUIRE -> LOCKED with error counting.
// Optional first-mismatch capture ports are enabled by DATA_CHECKER_FIRST_ERR_EN.
module data_checker
  import data_checker_pkg::*;
#(
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    ch_data,
  input  logic                 ch_valid,
  input  logic                 clr,
  output logic                 ck_locked,
  output logic                 ck_error,
  output logic                 ck_err_sticky,
  output logic [DATA_W-1:0]    ck_word_cnt,
  output logic [ERR_CNT_W-1:0] ck_err_cnt,
  output logic [DATA_W-1:0]    ck_expected
`ifdef DATA_CHECKER_FIRST_ERR_EN
  ,
  output logic [DATA_W-1:0]    ck_first_exp,
  output logic [DATA_W-1:0]    ck_first_got,
  output logic                 ck_first_vld
`endif
);

  localparam logic [7:0] LOCK_RUN = 8'(LOCK_CNT);

  state_t            state_reg;
  logic [7:0]        run_reg;
  logic [DATA_W-1:0] expected_reg;
  logic              locked_reg;
  logic              error_reg;
  logic              sticky_reg;

  logic word_match;
  logic word_take;
  logic err_take;

  assign word_match = (ch_data == expected_reg);
  // clr discards a word presented in the same cycle.
  assign word_take  = ch_valid && !clr;
  assign err_take   = word_take && (state_reg == ST_LOCKED) && !word_match;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_reg    <= ST_IDLE;
      run_reg      <= '0;
      expected_reg <= '0;
      locked_reg   <= 1'b0;
      error_reg    <= 1'b0;
      sticky_reg   <= 1'b0;
    end else begin
      error_reg <= 1'b0;
      if (ch_valid) begin
        case (state_reg)
          ST_IDLE: begin
            expected_reg <= next_word(ch_data);
            run_reg      <= 8'd1;
            state_reg    <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            expected_reg <= next_word(ch_data);
            if (word_match) begin
              run_reg <= run_reg + 8'd1;
              if (run_reg + 8'd1 == LOCK_RUN) begin
                state_reg  <= ST_LOCKED;
                locked_reg <= 1'b1;
              end
            end else begin
              run_reg <= 8'd1;
            end
          end
          ST_LOCKED: begin
            expected_reg <= next_word(ch_data);
            if (!word_match) begin
              error_reg  <= 1'b1;
              sticky_reg <= 1'b1;
              run_reg    <= 8'd1;
              state_reg  <= ST_ACQUIRE;
              locked_reg <= 1'b0;
            end
          end
          default: begin
            state_reg  <= ST_IDLE;
            run_reg    <= '0;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(DATA_W)) u_word_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (word_take),
    .cnt (ck_word_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_take),
    .cnt (ck_err_cnt)
  );

  assign ck_locked     = locked_reg;
  assign ck_error      = error_reg;
  assign ck_err_sticky = sticky_reg;
  assign ck_expected   = expected_reg;

`ifdef DATA_CHECKER_FIRST_ERR_EN
  logic [DATA_W-1:0] first_exp_reg;
  logic [DATA_W-1:0] first_got_reg;
  logic              first_vld_reg;

  // Only the first counted mismatch since reset/clear is retained.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      first_exp_reg <= '0;
      first_got_reg <= '0;
      first_vld_reg <= 1'b0;
    end else if (err_take && !first_vld_reg) begin
      first_exp_reg <= expected_reg;
      first_got_reg <= ch_data;
      first_vld_reg <= 1'b1;
    end
  end

  assign ck_first_exp = first_exp_reg;
  assign ck_first_got = first_got_reg;
  assign ck_first_vld = first_vld_reg;
`endif

endmodule

// File: tb/tb_data_checker.sv
// Self-checking bench for data_checker: directed scenarios plus randomized traffic
// compared against a behavioural sequence model.
module tb_data_checker;

  localparam int LOCK_CNT  = 4;
  localparam int ERR_CNT_W = 4;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic                 clk;
  logic                 rst;
  logic [31:0]          ch_data;
  logic                 ch_valid;
  logic                 clr;
  logic                 ck_locked;
  logic                 ck_error;
  logic                 ck_err_sticky;
  logic [31:0]          ck_word_cnt;
  logic [ERR_CNT_W-1:0] ck_err_cnt;
  logic [31:0]          ck_expected;
`ifdef DATA_CHECKER_FIRST_ERR_EN
  logic [31:0]          ck_first_exp;
  logic [31:0]          ck_first_got;
  logic                 ck_first_vld;
`endif

  data_checker #(.LOCK_CNT(LOCK_CNT), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_data       (ch_data),
    .ch_valid      (ch_valid),
    .clr           (clr),
    .ck_locked     (ck_locked),
    .ck_error      (ck_error),
    .ck_err_sticky (ck_err_sticky),
    .ck_word_cnt   (ck_word_cnt),
    .ck_err_cnt    (ck_err_cnt),
    .ck_expected   (ck_expected)
`ifdef DATA_CHECKER_FIRST_ERR_EN
    ,
    .ck_first_exp  (ck_first_exp),
    .ck_first_got  (ck_first_got),
    .ck_first_vld  (ck_first_vld)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Reference model: "active" means a sequence has been seeded; "run" is the
  // length of the current unbroken increasing run.
  bit                   m_active;
  bit                   m_locked;
  int                   m_run;
  logic [31:0]          m_exp;
  logic [31:0]          m_words;
  logic [ERR_CNT_W-1:0] m_errs;
  bit                   m_sticky;
  bit                   m_pulse;
  bit                   m_fvld;
  logic [31:0]          m_fexp;
  logic [31:0]          m_fgot;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_locked = 0; m_run = 0; m_exp = '0; m_words = '0;
    m_errs = '0; m_sticky = 0; m_pulse = 0; m_fvld = 0; m_fexp = '0; m_fgot = '0;
  endtask

  task automatic model_apply(input bit r, input bit c, input bit v, input logic [31:0] d);
    if (r || c) begin
      model_clear();
      return;
    end
    m_pulse = 0;
    if (!v) return;
    if (m_words != 32'hffffffff) m_words = m_words + 32'd1;
    if (!m_active) begin
      m_active = 1;
      m_run    = 1;
    end else if (d == m_exp) begin
      if (!m_locked) begin
        m_run++;
        if (m_run == LOCK_CNT) m_locked = 1;
      end
    end else begin
      if (m_locked) begin
        m_pulse  = 1;
        m_sticky = 1;
        if (m_errs != ERR_MAX) m_errs = m_errs + 1'b1;
        if (!m_fvld) begin
          m_fvld = 1; m_fexp = m_exp; m_fgot = d;
        end
        m_locked = 0;
      end
      m_run = 1;
    end
    m_exp = d + 32'd1;
  endtask

  task automatic step(input bit r, input bit c, input bit v, input logic [31:0] d);
    rst = r; clr = c; ch_valid = v; ch_data = d;
    @(posedge clk);
    #1;
    model_apply(r, c, v, d);
    n_txn++;
    check_eq("locked",   64'(ck_locked),     64'(m_locked));
    check_eq("error",    64'(ck_error),      64'(m_pulse));
    check_eq("sticky",   64'(ck_err_sticky), 64'(m_sticky));
    check_eq("word_cnt", 64'(ck_word_cnt),   64'(m_words));
    check_eq("err_cnt",  64'(ck_err_cnt),    64'(m_errs));
    check_eq("expected", 64'(ck_expected),   64'(m_exp));
`ifdef DATA_CHECKER_FIRST_ERR_EN
    check_eq("first_vld", 64'(ck_first_vld), 64'(m_fvld));
    check_eq("first_exp", 64'(ck_first_exp), 64'(m_fexp));
    check_eq("first_got", 64'(ck_first_got), 64'(m_fgot));
`endif
    $display("txn %0d rst=%0b clr=%0b vld=%0b data=%08h -> locked=%0b err=%0b words=%0d errs=%0d exp=%08h",
             n_txn, r, c, v, d, ck_locked, ck_error, ck_word_cnt, ck_err_cnt, ck_expected);
  endtask

  task automatic send(input logic [31:0] d);
    step(0, 0, 1, d);
  endtask

  task automatic send_run(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) send(first + 32'(i));
  endtask

  initial begin
    rst = 1; clr = 0; ch_valid = 0; ch_data = '0;
    model_clear();

    // Reset state
    step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h55);
    check_eq("reset_locked", 64'(ck_locked), 64'd0);
    check_eq("reset_expected", 64'(ck_expected), 64'd0);

    // Lock on 0,1,2,3
    send_run(32'd0, 3);
    check_eq("pre_lock", 64'(ck_locked), 64'd0);
    send(32'd3);
    check_eq("lock_after_4", 64'(ck_locked), 64'd1);
    check_eq("lock_words", 64'(ck_word_cnt), 64'd4);
    check_eq("lock_errs", 64'(ck_err_cnt), 64'd0);
    step(0, 0, 0, 32'hdead);  // idle cycle holds state

    // Wrap across 2^32 while locked
    step(1, 0, 0, 32'h0);
    send_run(32'hfffffffb, 4);
    send(32'hffffffff);
    send(32'h00000000);
    check_eq("wrap_locked", 64'(ck_locked), 64'd1);
    check_eq("wrap_expected", 64'(ck_expected), 64'd1);
    check_eq("wrap_no_err", 64'(ck_err_cnt), 64'd0);

    // Mismatch while locked, then relock
    step(1, 0, 0, 32'h0);
    send_run(32'd6, 4);
    send(32'd12);
    check_eq("mm_error", 64'(ck_error), 64'd1);
    check_eq("mm_errcnt", 64'(ck_err_cnt), 64'd1);
    check_eq("mm_unlocked", 64'(ck_locked), 64'd0);
    check_eq("mm_expected", 64'(ck_expected), 64'd13);
    step(0, 0, 0, 32'h0);
    check_eq("mm_pulse_1cyc", 64'(ck_error), 64'd0);
    send_run(32'd13, 3);
    check_eq("relocked", 64'(ck_locked), 64'd1);

    // Mismatch in ACQUIRE is not an error
    step(1, 0, 0, 32'h0);
    send(32'd5);
    send(32'd9);
    check_eq("acq_expected", 64'(ck_expected), 64'd10);
    check_eq("acq_errcnt", 64'(ck_err_cnt), 64'd0);
    check_eq("acq_error", 64'(ck_error), 64'd0);

    // clr with a valid word while locked
    send_run(32'd10, 3);
    step(0, 1, 1, 32'd13);
    check_eq("clr_words", 64'(ck_word_cnt), 64'd0);
    check_eq("clr_locked", 64'(ck_locked), 64'd0);
    send(32'd100);
    check_eq("clr_idle_seed", 64'(ck_expected), 64'd101);
    check_eq("clr_no_err", 64'(ck_error), 64'd0);

`ifdef DATA_CHECKER_FIRST_ERR_EN
    // First-mismatch capture keeps the earliest event only
    step(1, 0, 0, 32'h0);
    send_run(32'd3, 4);
    send(32'd9);
    send_run(32'd10, 10);
    send(32'd30);
    check_eq("first_exp_7", 64'(ck_first_exp), 64'd7);
    check_eq("first_got_9", 64'(ck_first_got), 64'd9);
    check_eq("first_vld_1", 64'(ck_first_vld), 64'd1);
`endif

    // Error counter saturation
    step(1, 0, 0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      send_run(32'(k * 100), LOCK_CNT);
      send(32'(k * 100 + 50));
    end
    check_eq("err_sat", 64'(ck_err_cnt), 64'(ERR_MAX));

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      logic [31:0] d;
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 99) < 85 && m_active) d = m_exp;
      else if ($urandom_range(0, 9) == 0) d = 32'hfffffffc + 32'($urandom_range(0, 3));
      else d = $urandom;
      if (r < 3)       step(1, 0, $urandom_range(0, 1) == 1, d);
      else if (r < 15) step(0, 1, $urandom_range(0, 1) == 1, d);
      else if (r < 800) step(0, 0, 1, d);
      else             step(0, 0, 0, d);
    end

    rst = 0; clr = 0; ch_valid = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_checker.md
DATA_CHECKER -- requirements
Module: data_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4, consecutive in-sequence words (including the seeding word) needed to enter LOCKED; legal 2..255.
REQ-002 Parameter ERR_CNT_W, default 16, width of the mismatch counter.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ch_data  input  32  received word; sampled only when ch_valid=1.
REQ-006 ch_valid  input  1  word-present qualifier; a single-cycle or back-to-back strobe, no backpressure.
REQ-007 clr  input  1  synchronous soft clear, same effect as rst.
REQ-008 ck_locked  output  1  high while the FSM is in LOCKED.
REQ-009 ck_error  output  1  one-cycle pulse per counted mismatch.
REQ-010 ck_err_sticky  output  1  set by the first counted mismatch; cleared only by rst or clr.
REQ-011 ck_word_cnt  output  32  words accepted, saturating at 32'hffffffff.
REQ-012 ck_err_cnt  output  ERR_CNT_W  counted mismatches, saturating at all-ones.
REQ-013 ck_expected  output  32  next expected word.

Function
REQ-014 The expected sequence is strictly incrementing modulo 2^32: after word D the expected word is D+1, and 32'hffffffff is followed by 32'h00000000.
REQ-015 FSM states are IDLE, ACQUIRE and LOCKED; IDLE is the reset state.
REQ-016 IDLE: a valid word seeds ck_expected=D+1, sets the run count to 1, and moves to ACQUIRE; no compare is performed.
REQ-017 ACQUIRE: a matching word increments the run count; when the count reaches LOCK_CNT the FSM moves to LOCKED.
REQ-018 ACQUIRE: a mismatching word reseeds ck_expected=D+1 and sets the run count to 1; it is not counted as an error.
REQ-019 LOCKED: a matching word advances ck_expected and the FSM stays in LOCKED.
REQ-020 LOCKED: a mismatching word pulses ck_error, increments ck_err_cnt, sets ck_err_sticky, reseeds ck_expected=D+1, sets the run count to 1, and moves to ACQUIRE.
REQ-021 Every valid word, in any state, increments ck_word_cnt.
REQ-022 All outputs are registered and reflect a word one cycle after the cycle in which ch_valid=1; cycles with ch_valid=0 leave all state unchanged and drive ck_error=0.
REQ-023 Back-to-back valid words are each checked, with no bubble required.
REQ-024 Counters saturate and never wrap; saturation does not affect FSM behaviour.

Reset
REQ-025 On rst=1 or clr=1 the FSM goes to IDLE and the run count is cleared.
REQ-026 On rst=1 or clr=1 the outputs reset as follows: ck_locked=0, ck_error=0, ck_err_sticky=0, ck_word_cnt=0, ck_err_cnt=0, ck_expected=32'h00000000.
REQ-027 rst has priority over clr, and clr has priority over ch_valid; a word presented in the same cycle as clr is discarded.

Configuration
REQ-028 Macro DATA_CHECKER_FIRST_ERR_EN, when defined, adds the following outputs: ck_first_exp (32), ck_first_got (32), ck_first_vld (1).
REQ-029 With DATA_CHECKER_FIRST_ERR_EN defined, the first counted mismatch after reset or clr captures the expected value and the received word, and sets ck_first_vld.
REQ-030 With DATA_CHECKER_FIRST_ERR_EN defined, later mismatches do not overwrite the captured values, and rst or clr zero all three outputs.
REQ-031 With DATA_CHECKER_FIRST_ERR_EN undefined, these ports and registers do not exist and all other behaviour is identical.

Structure
REQ-032 A shared package holds the FSM state enum, the data width constant (32), and the sequence wrap constant 32'hffffffff.
REQ-033 One sub-module, sat_counter, parameterised by width with inc and clr inputs, is instantiated for both ck_word_cnt and ck_err_cnt.

Verification
REQ-034 Scenario: reset, then 0,1,2,3 with LOCK_CNT=4 -> ck_locked=1 one cycle after word 3, ck_err_cnt=0, ck_word_cnt=4.
REQ-035 Scenario: locked, then 32'hfffffffe, 32'hffffffff, 0 -> no error; ck_expected=1.
REQ-036 Scenario: locked at expected 10, then send 12 -> ck_error pulses for 1 cycle, ck_err_cnt=1, ck_locked=0, ck_expected=13; then 13,14,15 -> relocked.
REQ-037 Scenario: in ACQUIRE, send 5,9 -> no error counted; run count restarts; ck_expected=10.
REQ-038 Scenario: clr asserted with ch_valid=1 while locked -> word discarded, all counters 0, FSM IDLE.
REQ-039 Scenario: with DATA_CHECKER_FIRST_ERR_EN, two mismatches (exp 7/got 9, then exp 20/got 30) -> ck_first_exp=7, ck_first_got=9, ck_first_vld=1.
